uart_frame_gen: RTL

Synthesizable, parametrised UART frame generator in the UART clock domain. It buffers words in a small FIFO, serialises each into a start/data/parity/stop frame with runtime-configurable oversampling, parity, stop-bit count and inter-frame gap, and can inject stop or parity errors on individual frames. It drives the system `RX_IN` line for self-test and in-system loopback, and it exercises the receiver's `stop_err`/`par_err` paths.

---
 rtl/uart_gen_pkg.sv | 20 ++
 rtl/uart_frame_fifo.sv | 83 ++++++++
 rtl/uart_frame_gen.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_gen_pkg.sv
// -----------------------------------------------------------------------------
// uart_gen_pkg
// Shared definitions for the UART frame generator: the frame FSM state
// encoding and the parity-type constants used to interpret cfg_par_typ.
// -----------------------------------------------------------------------------
package uart_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GAP
    } state_e;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_frame_fifo.sv
// -----------------------------------------------------------------------------
// uart_frame_fifo
// Small synchronous FIFO holding pending frames ({inj_par, inj_stop, data}).
// Read data is presented combinationally from the head entry so the frame
// generator can latch it on the same edge that pops it.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset (empties the FIFO)
//   push   in   write request (ignored when full)
//   pop    in   read request (ignored when empty)
//   wdata  in   WIDTH  entry to write
//   rdata  out  WIDTH  head entry
//   full   out  occupancy == DEPTH
//   empty  out  occupancy == 0
//   count  out  occupancy
// -----------------------------------------------------------------------------
module uart_frame_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_ptr_q];
    // Fullness is judged on the registered count, so a write while full is
    // refused even when a pop frees a slot on the same edge.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // Pointers wrap naturally since DEPTH is a power of two.
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_frame_gen.sv
// -----------------------------------------------------------------------------
// uart_frame_gen
// Buffers words in a small FIFO and serialises each into a UART frame
// (start, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits,
// optional idle gap). Individual frames can carry a forced-low stop or an
// inverted parity bit to exercise receiver error paths.
//
// Ports:
//   uart_clk      in   sole clock, rising edge
//   rst           in   asynchronous active-low reset
//   in_data       in   DATA_WIDTH word to send
//   in_inj_stop   in   per-frame: drive every stop bit low
//   in_inj_par    in   per-frame: invert the parity bit
//   in_valid      in   write request
//   in_ready      out  FIFO not full
//   cfg_prescale  in   PRESCALE_W uart_clk cycles per bit (0 acts as 1)
//   cfg_par_en    in   parity bit present
//   cfg_par_typ   in   0 = even, 1 = odd
//   cfg_stop2     in   two stop bits when set
//   cfg_gap       in   4  idle bit periods after the stop bits
//   tx_out        out  registered serial line, idle high
//   busy          out  FSM not idle
//   frame_done    out  pulse in the final cycle of each frame
//   fifo_cnt      out  FIFO occupancy
// -----------------------------------------------------------------------------
module uart_frame_gen
    import uart_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE_W = 6
) (
    input  logic                              uart_clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_inj_stop,
    input  logic                              in_inj_par,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [PRESCALE_W-1:0]             cfg_prescale,
    input  logic                              cfg_par_en,
    input  logic                              cfg_par_typ,
    input  logic                              cfg_stop2,
    input  logic [3:0]                        cfg_gap,
    output logic                              tx_out,
    output logic                              busy,
    output logic                              frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_cnt
);

    localparam int ENT_W = DATA_WIDTH + 2;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_e                  state_q, state_d;
    logic [PRESCALE_W-1:0]   timer_q, timer_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic                    stop_cnt_q, stop_cnt_d;
    logic [3:0]              gap_cnt_q, gap_cnt_d;
    logic                    tx_q, tx_d;

    // Per-frame copies of the FIFO entry and configuration.
    logic [PRESCALE_W-1:0]   presc_q, presc_d;      // bit period minus one
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    inj_stop_q, inj_stop_d;
    logic                    inj_par_q, inj_par_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic                    stop2_q, stop2_d;
    logic [3:0]              gap_q, gap_d;

    logic                    pop;
    logic                    launch;
    logic                    frame_end;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ENT_W-1:0]        fifo_rdata;
    logic [PRESCALE_W-1:0]   cfg_p_m1;
    logic                    parity;

    uart_frame_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (uart_clk),
        .rst   (rst),
        .push  (in_valid & in_ready),
        .pop   (pop),
        .wdata ({in_inj_par, in_inj_stop, in_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign in_ready   = ~fifo_full;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_end;
    assign tx_out     = tx_q;
    assign cfg_p_m1   = (cfg_prescale == '0) ? '0 : cfg_prescale - PRESCALE_W'(1);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_d      = bit_q;
        stop_cnt_d = stop_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        presc_d    = presc_q;
        data_d     = data_q;
        inj_stop_d = inj_stop_q;
        inj_par_d  = inj_par_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop2_d    = stop2_q;
        gap_d      = gap_q;
        pop        = 1'b0;
        launch     = 1'b0;
        frame_end  = 1'b0;
        tx_d       = 1'b1;
        parity     = 1'b0;

        if ((state_q != IDLE) && (timer_q != '0)) begin
            timer_d = timer_q - PRESCALE_W'(1);
        end else begin
            // Bit period boundary (or idle poll).
            case (state_q)
                IDLE: launch = ~fifo_empty;
                START: begin
                    state_d = DATA;
                    bit_d   = '0;
                    timer_d = presc_q;
                end
                DATA: begin
                    timer_d = presc_q;
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d    = par_en_q ? PARITY : STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
                PARITY: begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                    timer_d    = presc_q;
                end
                STOP: begin
                    if (stop_cnt_q == stop2_q) begin
                        if (gap_q != 4'd0) begin
                            state_d   = GAP;
                            gap_cnt_d = 4'd0;
                            timer_d   = presc_q;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                        timer_d    = presc_q;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == gap_q - 4'd1) begin
                        frame_end = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                        timer_d   = presc_q;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Chain straight into the next frame when work is queued.
            if (frame_end) begin
                if (!fifo_empty) launch = 1'b1;
                else             state_d = IDLE;
            end
        end

        // Entering START: pop and freeze entry plus configuration.
        if (launch) begin
            pop        = 1'b1;
            state_d    = START;
            timer_d    = cfg_p_m1;
            presc_d    = cfg_p_m1;
            data_d     = fifo_rdata[DATA_WIDTH-1:0];
            inj_stop_d = fifo_rdata[DATA_WIDTH];
            inj_par_d  = fifo_rdata[DATA_WIDTH+1];
            par_en_d   = cfg_par_en;
            par_typ_d  = cfg_par_typ;
            stop2_d    = cfg_stop2;
            gap_d      = cfg_gap;
        end

        // Line level is registered, so it is derived from the next state.
        parity = (^data_d) ^ (par_typ_d == ODD) ^ inj_par_d;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_d];
            PARITY:  tx_d = parity;
            STOP:    tx_d = ~inj_stop_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge uart_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_q      <= '0;
            stop_cnt_q <= 1'b0;
            gap_cnt_q  <= 4'd0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_q      <= bit_d;
            stop_cnt_q <= stop_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_q       <= tx_d;
        end
    end

    // Frame payload/config copies are only consumed after a launch loads them.
    always_ff @(posedge uart_clk) begin
        presc_q    <= presc_d;
        data_q     <= data_d;
        inj_stop_q <= inj_stop_d;
        inj_par_q  <= inj_par_d;
        par_en_q   <= par_en_d;
        par_typ_q  <= par_typ_d;
        stop2_q    <= stop2_d;
        gap_q      <= gap_d;
    end

endmodule
